// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and channel-index width helper for mux_arb_nx1.
package mux_pkg;
   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;
   function automatic int ch_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin / fixed-priority arbiter with its own rotating pointer.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = ch_w(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] req,
   input  logic            mode,
   input  logic            en,
   output logic [N_CH-1:0] gnt,
   output logic [CH_W-1:0] gnt_idx
);
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic            found;
   int              idx;
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int i = 0; i < N_CH; i++) begin
         idx = (mode == MODE_FIXED) ? i : (int'(ptr_q) + i) % N_CH;
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt_idx = CH_W'(idx);
         end
      end
   end
   assign gnt   = (found && en) ? ({{(N_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
   // Pointer advances in both modes so a return to round-robin stays fair.
   assign ptr_d = (found && en) ? ((gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
endmodule

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1: N-channel arbitrated mux with a registered valid/ready output stage.
module mux_arb_nx1
   import mux_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   parameter int CH_W  = ch_w(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic [N_CH-1:0]       in_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_ch,
   input  logic                  out_ready
);
   logic             load_en, xfer;
   logic [N_CH-1:0]  gnt;
   logic [CH_W-1:0]  gnt_idx;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]  out_ch_q, out_ch_d;
   assign load_en = !out_valid_q || out_ready;
   // Gating with rst_n keeps in_ready low for the whole reset interval.
   rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (in_valid),
      .mode   (mode),
      .en     (load_en && rst_n),
      .gnt    (gnt),
      .gnt_idx(gnt_idx)
   );
   assign in_ready = gnt;
   assign xfer     = |gnt;
   always_comb begin
      out_valid_d = xfer || (out_valid_q && !out_ready);
      out_data_d  = xfer ? in_data[gnt_idx*WIDTH +: WIDTH] : out_data_q;
      out_ch_d    = xfer ? gnt_idx : out_ch_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_mux_arb_nx1.sv
// tb_mux_arb_nx1: directed checks on a 4x8 instance plus scoreboarded sweeps on 3x16 and 8x8.
module tb_mux_arb_nx1;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mode = 1'b0;
   logic [3:0]  iv = '0;
   logic [31:0] id = '0;
   logic [3:0]  ir;
   logic        ov;
   logic [7:0]  od;
   logic [1:0]  oc;
   logic        ordy = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   logic [7:0]  sv [2];
   logic        sordy [2];
   logic [47:0] d3;
   logic [63:0] d8;
   logic [2:0]  rdy3;
   logic [7:0]  rdy8;
   logic        ov3, ov8;
   logic [15:0] od3;
   logic [7:0]  od8;
   logic [1:0]  oc3;
   logic [2:0]  oc8;
   int          prod [2][8];
   int          cons [2][8];
   int          wt [2][8];
   int          nch [2] = '{3, 8};

   always #5 clk = ~clk;

   mux_arb_nx1 #(.N_CH(4), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(iv), .in_data(id), .in_ready(ir),
      .out_valid(ov), .out_data(od), .out_ch(oc), .out_ready(ordy));
   mux_arb_nx1 #(.N_CH(3), .WIDTH(16)) u3 (
      .clk(clk), .rst_n(rst_n), .mode(1'b0), .in_valid(sv[0][2:0]), .in_data(d3), .in_ready(rdy3),
      .out_valid(ov3), .out_data(od3), .out_ch(oc3), .out_ready(sordy[0]));
   mux_arb_nx1 #(.N_CH(8), .WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .mode(1'b0), .in_valid(sv[1]), .in_data(d8), .in_ready(rdy8),
      .out_valid(ov8), .out_data(od8), .out_ch(oc8), .out_ready(sordy[1]));

   // Each word carries its channel tag and per-channel sequence number.
   always_comb begin
      d3 = '0;
      d8 = '0;
      for (int k = 0; k < 3; k++) d3[k*16 +: 16] = {4'(k), 12'(prod[0][k])};
      for (int k = 0; k < 8; k++) d8[k*8 +: 8] = {3'(k), 5'(prod[1][k])};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      iv = 4'b1111;
      #1 rst_n = 1'b0;
      #2;
      n_cmp++; if ({ov, oc, od} !== 11'd0) begin n_err++; $display("FAIL reset_out got v=%b ch=%0d d=%h exp 0", ov, oc, od); end
      n_cmp++; if (ir !== 4'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0000", ir); end
      @(negedge clk) rst_n = 1'b1;
      iv = 4'b0;
   endtask

   task automatic test_rr();
      mode = 1'b0; ordy = 1'b1;
      id = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      iv = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if (ir !== 4'(1 << (k % 4))) begin n_err++; $display("FAIL rr_ready[%0d] got %b exp %b", k, ir, 4'(1 << (k % 4))); end
         step();
         n_cmp++; if ({ov, oc, od} !== {1'b1, 2'(k % 4), 8'hA0 + 8'(k % 4)}) begin n_err++; $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp ch=%0d", k, ov, oc, od, k % 4); end
      end
      iv = 4'b0;
      step();
      n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL rr_drain got %b exp 0", ov); end
   endtask

   task automatic test_fixed();
      mode = 1'b1;
      id = {8'h13, 8'h12, 8'h11, 8'h10};
      iv = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (ir !== 4'b0010) begin n_err++; $display("FAIL fix_ready[%0d] got %b exp 0010", k, ir); end
         step();
         n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd1, 8'h11}) begin n_err++; $display("FAIL fix_out[%0d] got v=%b ch=%0d d=%h exp ch=1 d=11", k, ov, oc, od); end
      end
      mode = 1'b0;
      #1;
      n_cmp++; if (ir !== 4'b1000) begin n_err++; $display("FAIL fix_to_rr_ready got %b exp 1000", ir); end
      step();
      n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd3, 8'h13}) begin n_err++; $display("FAIL fix_to_rr_out got ch=%0d d=%h exp ch=3 d=13", oc, od); end
      iv = 4'b0;
      step();
      n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL fix_drain got %b exp 0", ov); end
   endtask

   task automatic test_backpressure();
      id = {8'h23, 8'h22, 8'h21, 8'h20};
      iv = 4'b0101; ordy = 1'b0;
      step();
      n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd0, 8'h20}) begin n_err++; $display("FAIL bp_load got v=%b ch=%0d d=%h exp ch=0 d=20", ov, oc, od); end
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (ir !== 4'b0) begin n_err++; $display("FAIL bp_ready[%0d] got %b exp 0000", k, ir); end
         step();
         n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd0, 8'h20}) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h exp ch=0 d=20", k, ov, oc, od); end
      end
      ordy = 1'b1;
      #1;
      n_cmp++; if (ir !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready got %b exp 0100", ir); end
      step();
      n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd2, 8'h22}) begin n_err++; $display("FAIL bp_release_out got ch=%0d d=%h exp ch=2 d=22", oc, od); end
      iv = 4'b0;
      step();
      n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b exp 0", ov); end
   endtask

   task automatic test_wrap();
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      id = {8'h33, 8'h32, 8'h31, 8'h30};
      iv = 4'b1000;
      step();
      n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd3, 8'h33}) begin n_err++; $display("FAIL wrap_ch3 got ch=%0d d=%h exp ch=3", oc, od); end
      iv = 4'b1111;
      step();
      n_cmp++; if (oc !== 2'd0) begin n_err++; $display("FAIL wrap_ptr0 got ch=%0d exp 0", oc); end
      iv = 4'b0001;
      step();
      n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd0, 8'h30}) begin n_err++; $display("FAIL wrap_ch0 got ch=%0d d=%h exp ch=0", oc, od); end
      iv = 4'b0;
      step();
      n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL wrap_drain got %b exp 0", ov); end
      iv = 4'b1111;
      step();
      n_cmp++; if ({ov, oc} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL wrap_ptr1 got ch=%0d exp 1", oc); end
      iv = 4'b0;
      step();
   endtask

   task automatic test_mid_reset();
      ordy = 1'b0;
      iv = 4'b0001;
      step();
      n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd0, 8'h30}) begin n_err++; $display("FAIL mr_load got v=%b ch=%0d d=%h exp ch=0 d=30", ov, oc, od); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({ov, oc, od} !== 11'd0) begin n_err++; $display("FAIL mr_async got v=%b ch=%0d d=%h exp 0", ov, oc, od); end
      n_cmp++; if (ir !== 4'b0) begin n_err++; $display("FAIL mr_ready got %b exp 0000", ir); end
      @(negedge clk) rst_n = 1'b1;
      #1;
      n_cmp++; if (ir !== 4'b0001) begin n_err++; $display("FAIL mr_rearm got %b exp 0001", ir); end
      step();
      n_cmp++; if ({ov, oc, od} !== {1'b1, 2'd0, 8'h30}) begin n_err++; $display("FAIL mr_reload got v=%b ch=%0d d=%h", ov, oc, od); end
      iv = 4'b0; ordy = 1'b1;
      step();
   endtask

   task automatic test_sweep();
      logic [7:0]  g;
      logic [7:0]  rdy;
      logic        v;
      logic [15:0] d;
      int          ch, gi, tag, sq;
      logic [7:0]  gl [2];
      gl[0] = '0; gl[1] = '0;
      for (int j = 0; j < 2; j++) for (int k = 0; k < 8; k++) begin prod[j][k] = 0; cons[j][k] = 0; wt[j][k] = 0; end
      sv[0] = '0; sv[1] = '0; sordy[0] = 1'b0; sordy[1] = 1'b0;
      for (int c = 0; c < 440; c++) begin
         step();
         for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < nch[j]; k++) begin
               if (gl[j][k]) prod[j][k]++;
               sv[j][k] = (c < 400) && ((sv[j][k] && !gl[j][k]) || ($urandom_range(0, 1) == 1));
            end
            sordy[j] = (c >= 400) || ($urandom_range(0, 3) != 0);
         end
         #3;
         for (int j = 0; j < 2; j++) begin
            rdy = (j == 0) ? {5'b0, rdy3} : rdy8;
            g = sv[j] & rdy;
            gl[j] = g;
            n_cmp++; if (!$onehot0(g) || (g !== rdy)) begin n_err++; $display("FAIL sw%0d_onehot got %b req %b", j, rdy, sv[j]); end
            if (g != 0) begin
               gi = $clog2(int'(g));
               for (int k = 0; k < nch[j]; k++) begin
                  if (k == gi) wt[j][k] = 0;
                  else if (sv[j][k]) begin
                     wt[j][k]++;
                     n_cmp++; if (wt[j][k] > nch[j] - 1) begin n_err++; $display("FAIL sw%0d_fair ch%0d waited %0d grants max %0d", j, k, wt[j][k], nch[j] - 1); end
                  end
               end
            end
            v  = (j == 0) ? ov3 : ov8;
            d  = (j == 0) ? od3 : {8'b0, od8};
            ch = (j == 0) ? int'(oc3) : int'(oc8);
            if (v && sordy[j]) begin
               tag = (j == 0) ? int'(d[15:12]) : int'(d[7:5]);
               sq  = (j == 0) ? int'(d[11:0]) : int'(d[4:0]);
               n_cmp++; if (tag !== ch || sq !== ((j == 0) ? cons[j][ch] % 4096 : cons[j][ch] % 32)) begin
                  n_err++; $display("FAIL sw%0d_word ch=%0d tag=%0d seq=%0d exp seq=%0d", j, ch, tag, sq, cons[j][ch]);
               end
               cons[j][ch]++;
            end
         end
      end
      for (int j = 0; j < 2; j++) for (int k = 0; k < nch[j]; k++) begin
         n_cmp++; if (cons[j][k] !== prod[j][k] || prod[j][k] == 0) begin n_err++; $display("FAIL sw%0d_count ch%0d got %0d exp %0d", j, k, cons[j][k], prod[j][k]); end
      end
   endtask

   initial begin
      sv[0] = '0; sv[1] = '0; sordy[0] = 1'b0; sordy[1] = 1'b0;
      test_reset();
      test_rr();
      test_fixed();
      test_backpressure();
      test_wrap();
      test_mid_reset();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
